// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encodings for the bit-serial adder
package serial_adder_pkg;

   localparam int ST_W = 2;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - 1-bit full adder built from two half adders
module half_adder (
   input  logic A,
   input  logic B,
   output logic SUM,
   output logic CARRY
);

   assign SUM   = A ^ B;
   assign CARRY = A & B;

endmodule

module full_adder (
   input  logic A,
   input  logic B,
   input  logic CIN,
   output logic SUM,
   output logic COUT
);

   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (.A(A),  .B(B),   .SUM(s0),  .CARRY(c0));
   half_adder u_ha1 (.A(s0), .B(CIN), .SUM(SUM), .CARRY(c1));

   // At most one of the two half-adder carries can be set, so OR is exact.
   assign COUT = c0 | c1;

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial WIDTH-bit adder, LSB first, START/BUSY/DONE handshake
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             CIN,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] SUM,
   output logic             COUT
);

   state_t             state;
   state_t             state_n;
   logic [WIDTH-1:0]   sa;
   logic [WIDTH-1:0]   sb;
   logic [WIDTH-2:0]   res;
   logic [WIDTH-1:0]   res_cat;
   logic               carry;
   logic [CNT_W-1:0]   cnt;
   logic               fa_sum;
   logic               fa_cout;
   logic               accept;
   logic               last;
   logic [WIDTH-1:0]   sum_q;
   logic               cout_q;

   full_adder u_fa (
      .A    (sa[0]),
      .B    (sb[0]),
      .CIN  (carry),
      .SUM  (fa_sum),
      .COUT (fa_cout)
   );

   assign accept  = START && (state == ST_IDLE || state == ST_FINISH);
   assign last    = (cnt == CNT_W'(WIDTH - 1));
   // New bit enters at the top; the full word is the result on the final bit.
   assign res_cat = {fa_sum, res};

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      BUSY    = 1'b0;
      DONE    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (START) state_n = ST_RUN;
         end
         ST_RUN: begin
            BUSY = 1'b1;
            if (last) state_n = ST_FINISH;
         end
         ST_FINISH: begin
            DONE    = 1'b1;
            state_n = START ? ST_RUN : ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sa     <= '0;
         sb     <= '0;
         res    <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else if (accept) begin
         sa    <= A;
         sb    <= B;
         carry <= CIN;
         cnt   <= '0;
      end else if (state == ST_RUN) begin
         sa    <= sa >> 1;
         sb    <= sb >> 1;
         carry <= fa_cout;
         res   <= res_cat[WIDTH-1:1];
         cnt   <= cnt + CNT_W'(1);
         if (last) begin
            sum_q  <= res_cat;
            cout_q <= fa_cout;
         end
      end
   end

   assign SUM  = sum_q;
   assign COUT = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - directed self-checking bench for serial_adder
module tb_serial_adder;

   localparam int WIDTH = 8;

   logic             CLK;
   logic             RST_N;
   logic             START;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
   logic             BUSY;
   logic             DONE;
   logic [WIDTH-1:0] SUM;
   logic             COUT;

   int n_chk  = 0;
   int n_pass = 0;

   serial_adder #(.WIDTH(WIDTH), .CNT_W(4)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .A     (A),
      .B     (B),
      .CIN   (CIN),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .SUM   (SUM),
      .COUT  (COUT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   // Accept one add, optionally poke A/START mid-run, and check the whole transaction.
   task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic [7:0] exp_sum, input logic exp_cout,
                          input logic [7:0] prev_sum, input bit poke);
      int busy_cnt;
      bit held;
      busy_cnt = 0;
      held     = 1'b1;
      @(negedge CLK);
      A = a; B = b; CIN = cin; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      A = ~a; B = ~b; CIN = ~cin;
      for (int i = 0; i < WIDTH; i++) begin
         if (BUSY && !DONE) busy_cnt++;
         if (SUM !== prev_sum) held = 1'b0;
         if (poke && i == 2) begin A = 8'hFF; START = 1'b1; end
         if (poke && i == 3) START = 1'b0;
         @(negedge CLK);
      end
      check({tag, "_busy_cycles"}, busy_cnt, WIDTH);
      check({tag, "_sum_held"}, held, 1);
      check({tag, "_done"}, {BUSY, DONE}, 2'b01);
      check({tag, "_sum"}, SUM, exp_sum);
      check({tag, "_cout"}, COUT, exp_cout);
      @(negedge CLK);
      check({tag, "_done_drop"}, {BUSY, DONE}, 2'b00);
   endtask

   initial begin
      int  done_seen;
      int  pulses;
      int  last_idx;
      bit  spacing_ok;

      RST_N = 1'b0; START = 1'b0; A = '0; B = '0; CIN = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_busy", BUSY, 0);
      check("rst_done", DONE, 0);
      check("rst_sum", SUM, 8'h00);
      check("rst_cout", COUT, 0);

      run_add("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'h00, 1'b0);
      run_add("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 8'h00, 1'b0);
      run_add("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 8'h00, 1'b1);

      // Abort a 12+34 add mid-run with reset.
      @(negedge CLK);
      A = 8'h12; B = 8'h34; CIN = 1'b0; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      repeat (4) @(negedge CLK);
      check("abort_busy_pre", BUSY, 1);
      RST_N = 1'b0;
      #1;
      check("abort_busy", BUSY, 0);
      check("abort_sum", SUM, 8'h00);
      check("abort_done", DONE, 0);
      repeat (2) @(negedge CLK);
      RST_N = 1'b1;
      done_seen = 0;
      repeat (12) begin
         @(negedge CLK);
         if (DONE || BUSY) done_seen++;
      end
      check("abort_no_activity", done_seen, 0);
      run_add("12_34", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'h00, 1'b0);

      // Continuous START: expect a DONE every WIDTH+1 cycles.
      @(negedge CLK);
      A = 8'h80; B = 8'h80; CIN = 1'b0; START = 1'b1;
      pulses     = 0;
      last_idx   = -1;
      spacing_ok = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge CLK);
         if (DONE) begin
            pulses++;
            check("b2b_sum", SUM, 8'h00);
            check("b2b_cout", COUT, 1);
            if (last_idx >= 0 && i - last_idx != WIDTH + 1) spacing_ok = 1'b0;
            if (last_idx < 0 && i != WIDTH) spacing_ok = 1'b0;
            last_idx = i;
         end
      end
      START = 1'b0;
      check("b2b_pulses", pulses, 3);
      check("b2b_spacing", spacing_ok, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
